mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported main_memory between the fetch port and the load/store port of pipeline_top.
//  Sits between pipeline_top and main_memory in core_top and replaces the split imem/dmem wiring.
//  Grants at most one access per cycle and stalls the losing requester.
//  Tags each read so that its data returns to the port that issued it.
// PARAMETERS
//  RD_LAT       1  memory read latency in cycles (legal: 1..3); the tag pipeline depth equals RD_LAT
//  MAX_LS_RUN   4  consecutive LS grants allowed while IF is pending, before IF is forced once
// PORTS
//  clk            in   1   core clock; all state changes on its rising edge
//  rst            in   1   asynchronous, active-high reset
//  i_if_req       in   1   fetch request; held stable while o_if_stall=1
//  i_if_addr      in   32  fetch address
//  o_if_instr     out  32  fetched instruction; meaningful only when o_if_valid=1
//  o_if_valid     out  1   1-cycle pulse; o_if_instr carries the data of the oldest granted fetch
//  o_if_stall     out  1   fetch request present but not granted this cycle
//  i_ls_rd_en     in   1   load request
//  i_ls_wr_en     in   1   store request (rd_en and wr_en are never both 1)
//  i_ls_addr      in   32  load/store address
//  i_ls_wdata     in   32  store data
//  i_ls_wr_type   in   2   store size code, passed through
//  i_ls_rd_type   in   3   load size/sign code, passed through
//  o_ls_rdata     out  32  load data; meaningful only when o_ls_valid=1
//  o_ls_valid     out  1   1-cycle pulse: load data returned, or store accepted
//  o_ls_stall     out  1   LS request present but not granted this cycle
//  o_mem_addr     out  32  to main_memory
//  o_mem_wdata    out  32  to main_memory
//  o_mem_wr_type  out  2   to main_memory
//  o_mem_rd_type  out  3   to main_memory
//  o_mem_wr_en    out  1   to main_memory
//  o_mem_rd_en    out  1   to main_memory
//  i_mem_rdata    in   32  from main_memory; valid exactly RD_LAT cycles after o_mem_rd_en
// BEHAVIOUR
//  Reset (async, rst=1): all outputs 0, tag pipeline cleared, run counter=0, FSM=ARB_LS_PRI.
//  Grant decision is combinational from the current requests and FSM state; o_mem_* driven the same cycle.
//  FSM states:
//   ARB_LS_PRI: LS wins any conflict. Each LS grant while i_if_req=1 increments run_cnt.
//               When run_cnt reaches MAX_LS_RUN, move to ARB_IF_FORCE.
//   ARB_IF_FORCE: IF wins the next conflict; on that IF grant, clear run_cnt and return to ARB_LS_PRI.
//               If i_if_req drops before being granted, clear run_cnt and return to ARB_LS_PRI.
//  run_cnt clears on any cycle with i_if_req=0.
//  Winner's address and controls drive o_mem_*.
//   Loser: o_*_stall=1 and no o_mem_* effect.
//   No request: o_mem_rd_en=o_mem_wr_en=0; addr/wdata hold their last value.
//  An IF grant always issues o_mem_rd_en=1 with rd_type=3'b010 (word).
//  Tag pipeline: RD_LAT-deep shift of {vld, owner}.
//   Each read grant pushes vld=1 and owner=IF/LS. At the output stage, vld routes i_mem_rdata to the owner's rdata.
//   The owner's valid pulses for that cycle; the other port's valid stays 0.
//  Store: o_ls_valid pulses the cycle after the grant (registered). Stores push vld=0 into the tag pipe.
//  A write and a read-return may coincide, but never both on LS.
//   Resolution: if a store ack and an LS load return fall in the same cycle, the store ack is delayed one cycle.
//   In practice RD_LAT=1 makes this impossible; it is legal for RD_LAT>1.
//  Order: returns are in grant order; there is exactly one response per grant and none is dropped.
//  Reset mid-flight: tag pipe is flushed, in-flight reads are discarded, and no valid pulse follows reset.
//  No combinational path from i_mem_rdata to o_*_stall.
// STRUCTURE
//  Shared package mem_arb_pkg: owner encoding (OWN_IF=1'b0, OWN_LS=1'b1), FSM state encodings,
//   and the word rd_type constant RD_WORD=3'b010.
//  One sub-module, mem_arb_tag_pipe: a parameterised RD_LAT-deep {vld,owner} shift register with a flush input.
//  core_top instantiates pipeline_top -> mem_port_arbiter -> main_memory.
// TESTING
//  1. IF-only stream at 0x0,0x4,0x8 -> o_if_stall=0 throughout.
//     o_if_valid pulses RD_LAT cycles after each request with the memory word.
//  2. IF and LS load to 0x100 in the same cycle -> LS granted and o_if_stall=1.
//     IF granted the next cycle; returns arrive in order LS then IF.
//  3. LS load every cycle plus IF held, MAX_LS_RUN=4 -> exactly 4 LS grants, then 1 IF grant (o_ls_stall=1 that cycle).
//  4. Store 0xDEADBEEF to 0x200 (wr_type word), then load 0x200 -> o_ls_valid ack after the store.
//     The load returns 0xDEADBEEF.
//  5. Assert rst while 2 reads are in flight (RD_LAT=2) -> all outputs 0 immediately.
//     No o_if_valid or o_ls_valid pulse in the following 3 cycles.
//  6. No requests for 5 cycles -> o_mem_rd_en=o_mem_wr_en=0, and both stalls and both valids stay 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the fetch / load-store memory port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  typedef enum logic {
    ARB_LS_PRI   = 1'b0,
    ARB_IF_FORCE = 1'b1
  } arb_state_e;

  localparam logic [2:0] RD_WORD = 3'b010;

  typedef struct packed {
    logic   vld;
    owner_e owner;
  } tag_t;

endpackage

// File: rtl/mem_arb_tag_pipe.sv
// RD_LAT-deep {vld, owner} shift register; o_tag lines up with the memory read data.
// flush clears every stage immediately so no stale return survives it.
module mem_arb_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic flush,
  input  tag_t i_tag,
  output tag_t o_tag
);

  tag_t pipe_q [RD_LAT];
  tag_t pipe_d [RD_LAT];

  always_comb begin
    pipe_d[0] = i_tag;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge flush) begin
    if (flush) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign o_tag = pipe_q[RD_LAT-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and load/store; one grant per cycle,
// LS-priority with a forced IF grant after MAX_LS_RUN consecutive LS wins.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int RD_LAT     = 1,
  parameter int MAX_LS_RUN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic [31:0] o_if_instr,
  output logic        o_if_valid,
  output logic        o_if_stall,
  input  logic        i_ls_rd_en,
  input  logic        i_ls_wr_en,
  input  logic [31:0] i_ls_addr,
  input  logic [31:0] i_ls_wdata,
  input  logic [1:0]  i_ls_wr_type,
  input  logic [2:0]  i_ls_rd_type,
  output logic [31:0] o_ls_rdata,
  output logic        o_ls_valid,
  output logic        o_ls_stall,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [1:0]  o_mem_wr_type,
  output logic [2:0]  o_mem_rd_type,
  output logic        o_mem_wr_en,
  output logic        o_mem_rd_en,
  input  logic [31:0] i_mem_rdata
);

  localparam int CNT_W = $clog2(MAX_LS_RUN + 1);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [1:0]       wr_type_q, wr_type_d;
  logic [2:0]       rd_type_q, rd_type_d;
  logic [2:0]       st_pend_q, st_pend_d;

  logic ls_req, if_gnt, ls_gnt, st_gnt;
  logic if_ret, ls_ret, ack_fire;
  tag_t push_tag, ret_tag;

  assign ls_req = i_ls_rd_en | i_ls_wr_en;

  // Grants are suppressed while reset is held so every output reads 0.
  always_comb begin
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    if (!rst) begin
      if (state_q == ARB_IF_FORCE) begin
        if (i_if_req) if_gnt = 1'b1;
        else          ls_gnt = ls_req;
      end else begin
        if (ls_req) ls_gnt = 1'b1;
        else        if_gnt = i_if_req;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    if (!i_if_req) begin
      state_d   = ARB_LS_PRI;
      run_cnt_d = '0;
    end else if (state_q == ARB_LS_PRI) begin
      if (ls_gnt) begin
        run_cnt_d = run_cnt_q + 1'b1;
        if (run_cnt_d == CNT_W'(MAX_LS_RUN)) state_d = ARB_IF_FORCE;
      end
    end else if (if_gnt) begin
      state_d   = ARB_LS_PRI;
      run_cnt_d = '0;
    end
  end

  // Address and controls hold their last granted value on idle cycles.
  always_comb begin
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wr_type_d = wr_type_q;
    rd_type_d = rd_type_q;
    if (if_gnt) begin
      addr_d    = i_if_addr;
      rd_type_d = RD_WORD;
    end else if (ls_gnt) begin
      addr_d    = i_ls_addr;
      wdata_d   = i_ls_wdata;
      wr_type_d = i_ls_wr_type;
      rd_type_d = i_ls_rd_type;
    end
  end

  assign st_gnt        = ls_gnt & i_ls_wr_en;
  assign o_mem_addr    = addr_d;
  assign o_mem_wdata   = wdata_d;
  assign o_mem_wr_type = wr_type_d;
  assign o_mem_rd_type = rd_type_d;
  assign o_mem_rd_en   = if_gnt | (ls_gnt & i_ls_rd_en);
  assign o_mem_wr_en   = st_gnt;

  assign o_if_stall = i_if_req & ~if_gnt & ~rst;
  assign o_ls_stall = ls_req & ~ls_gnt & ~rst;

  assign push_tag.vld   = o_mem_rd_en;
  assign push_tag.owner = if_gnt ? OWN_IF : OWN_LS;

  mem_arb_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tag_pipe (
    .clk   (clk),
    .flush (rst),
    .i_tag (push_tag),
    .o_tag (ret_tag)
  );

  assign if_ret = ret_tag.vld & (ret_tag.owner == OWN_IF);
  assign ls_ret = ret_tag.vld & (ret_tag.owner == OWN_LS);

  // A store ack yields to an LS load return in the same cycle and waits here.
  assign ack_fire  = (st_pend_q != 3'd0) & ~ls_ret;
  assign st_pend_d = st_pend_q + 3'(st_gnt) - 3'(ack_fire);

  assign o_if_valid = if_ret;
  assign o_if_instr = if_ret ? i_mem_rdata : 32'h0;
  assign o_ls_valid = ls_ret | ack_fire;
  assign o_ls_rdata = ls_ret ? i_mem_rdata : 32'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ARB_LS_PRI;
      run_cnt_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_type_q <= '0;
      rd_type_q <= '0;
      st_pend_q <= '0;
    end else begin
      state_q   <= state_d;
      run_cnt_q <= run_cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wr_type_q <= wr_type_d;
      rd_type_q <= rd_type_d;
      st_pend_q <= st_pend_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with RD_LAT=2 and a behavioural memory.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic [31:0] o_if_instr;
  logic        o_if_valid;
  logic        o_if_stall;
  logic        i_ls_rd_en;
  logic        i_ls_wr_en;
  logic [31:0] i_ls_addr;
  logic [31:0] i_ls_wdata;
  logic [1:0]  i_ls_wr_type;
  logic [2:0]  i_ls_rd_type;
  logic [31:0] o_ls_rdata;
  logic        o_ls_valid;
  logic        o_ls_stall;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [1:0]  o_mem_wr_type;
  logic [2:0]  o_mem_rd_type;
  logic        o_mem_wr_en;
  logic        o_mem_rd_en;
  logic [31:0] i_mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  mem_port_arbiter #(
    .RD_LAT     (2),
    .MAX_LS_RUN (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_if_req      (i_if_req),
    .i_if_addr     (i_if_addr),
    .o_if_instr    (o_if_instr),
    .o_if_valid    (o_if_valid),
    .o_if_stall    (o_if_stall),
    .i_ls_rd_en    (i_ls_rd_en),
    .i_ls_wr_en    (i_ls_wr_en),
    .i_ls_addr     (i_ls_addr),
    .i_ls_wdata    (i_ls_wdata),
    .i_ls_wr_type  (i_ls_wr_type),
    .i_ls_rd_type  (i_ls_rd_type),
    .o_ls_rdata    (o_ls_rdata),
    .o_ls_valid    (o_ls_valid),
    .o_ls_stall    (o_ls_stall),
    .o_mem_addr    (o_mem_addr),
    .o_mem_wdata   (o_mem_wdata),
    .o_mem_wr_type (o_mem_wr_type),
    .o_mem_rd_type (o_mem_rd_type),
    .o_mem_wr_en   (o_mem_wr_en),
    .o_mem_rd_en   (o_mem_rd_en),
    .i_mem_rdata   (i_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory: word index i holds 0xA0000000+i after reset; 2-cycle read latency.
  logic [31:0] mem [256];
  logic [31:0] rd_p1, rd_p2;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 + 32'(i);
    end else if (o_mem_wr_en) begin
      mem[o_mem_addr[9:2]] <= o_mem_wdata;
    end
    rd_p1 <= o_mem_rd_en ? mem[o_mem_addr[9:2]] : 32'h0;
    rd_p2 <= rd_p1;
  end
  assign i_mem_rdata = rd_p2;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic idle();
    i_if_req     = 1'b0;
    i_if_addr    = 32'h0;
    i_ls_rd_en   = 1'b0;
    i_ls_wr_en   = 1'b0;
    i_ls_addr    = 32'h0;
    i_ls_wdata   = 32'h0;
    i_ls_wr_type = 2'b00;
    i_ls_rd_type = 3'b000;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_rd_en"},    32'(o_mem_rd_en), 32'd0);
    check({tag, "_wr_en"},    32'(o_mem_wr_en), 32'd0);
    check({tag, "_if_stall"}, 32'(o_if_stall),  32'd0);
    check({tag, "_ls_stall"}, 32'(o_ls_stall),  32'd0);
    check({tag, "_if_valid"}, 32'(o_if_valid),  32'd0);
    check({tag, "_ls_valid"}, 32'(o_ls_valid),  32'd0);
  endtask

  logic exp_ls_stall [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic exp_if_stall [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic exp_ls_vld   [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic exp_if_vld   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [31:0] exp_ls_dat [8] = '{32'h0, 32'h0, 32'hA000_0004, 32'hA000_0005,
                                  32'hA000_0006, 32'hA000_0007, 32'h0, 32'hA000_00C0};

  initial begin
    rst = 1'b1;
    idle();
    i_if_req   = 1'b1;
    i_ls_rd_en = 1'b1;
    i_ls_addr  = 32'h44;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("rst");
    check("rst_addr", o_mem_addr, 32'h0);
    cyc();
    rst = 1'b0;
    idle();

    // 1: IF-only stream
    for (int c = 0; c < 6; c++) begin
      cyc();
      idle();
      if (c < 3) begin
        i_if_req  = 1'b1;
        i_if_addr = 32'(4 * c);
      end
      @(negedge clk);
      check("t1_if_stall", 32'(o_if_stall), 32'd0);
      if (c < 3) begin
        check("t1_rd_en", 32'(o_mem_rd_en), 32'd1);
        check("t1_addr", o_mem_addr, 32'(4 * c));
        check("t1_rd_type", 32'(o_mem_rd_type), 32'd2);
      end
      check("t1_if_valid", 32'(o_if_valid), 32'(c >= 2 && c < 5));
      if (c >= 2 && c < 5) check("t1_instr", o_if_instr, 32'hA000_0000 + 32'(c - 2));
    end

    // 2: simultaneous IF and LS load
    cyc();
    i_if_req = 1'b1; i_if_addr = 32'hC;
    i_ls_rd_en = 1'b1; i_ls_addr = 32'h100; i_ls_rd_type = 3'b100;
    @(negedge clk);
    check("t2_ls_stall", 32'(o_ls_stall), 32'd0);
    check("t2_if_stall", 32'(o_if_stall), 32'd1);
    check("t2_addr_ls", o_mem_addr, 32'h100);
    check("t2_rd_type_ls", 32'(o_mem_rd_type), 32'd4);
    cyc();
    i_ls_rd_en = 1'b0;
    @(negedge clk);
    check("t2_if_gnt", 32'(o_if_stall), 32'd0);
    check("t2_addr_if", o_mem_addr, 32'hC);
    check("t2_rd_type_if", 32'(o_mem_rd_type), 32'd2);
    cyc();
    idle();
    @(negedge clk);
    check("t2_ls_valid", 32'(o_ls_valid), 32'd1);
    check("t2_ls_rdata", o_ls_rdata, 32'hA000_0040);
    check("t2_if_valid_early", 32'(o_if_valid), 32'd0);
    cyc();
    @(negedge clk);
    check("t2_if_valid", 32'(o_if_valid), 32'd1);
    check("t2_if_instr", o_if_instr, 32'hA000_0003);
    check("t2_ls_valid_late", 32'(o_ls_valid), 32'd0);

    // 3: LS streak against a held IF request
    for (int k = 0; k < 8; k++) begin
      cyc();
      idle();
      if (k <= 4) begin
        i_if_req  = 1'b1;
        i_if_addr = 32'h20;
      end
      if (k <= 5) begin
        i_ls_rd_en   = 1'b1;
        i_ls_addr    = (k < 4) ? 32'h10 + 32'(4 * k) : 32'h300;
        i_ls_rd_type = 3'b010;
      end
      @(negedge clk);
      check($sformatf("t3_ls_stall_%0d", k), 32'(o_ls_stall), 32'(exp_ls_stall[k]));
      check($sformatf("t3_if_stall_%0d", k), 32'(o_if_stall), 32'(exp_if_stall[k]));
      check($sformatf("t3_ls_vld_%0d", k), 32'(o_ls_valid), 32'(exp_ls_vld[k]));
      check($sformatf("t3_if_vld_%0d", k), 32'(o_if_valid), 32'(exp_if_vld[k]));
      if (exp_ls_vld[k]) check($sformatf("t3_ls_dat_%0d", k), o_ls_rdata, exp_ls_dat[k]);
      if (k == 4) check("t3_force_addr", o_mem_addr, 32'h20);
      if (k == 6) check("t3_if_instr", o_if_instr, 32'hA000_0008);
    end

    // 4: store then load back
    cyc();
    idle();
    i_ls_wr_en = 1'b1; i_ls_addr = 32'h200; i_ls_wdata = 32'hDEAD_BEEF; i_ls_wr_type = 2'b10;
    @(negedge clk);
    check("t4_wr_en", 32'(o_mem_wr_en), 32'd1);
    check("t4_rd_en", 32'(o_mem_rd_en), 32'd0);
    check("t4_addr", o_mem_addr, 32'h200);
    check("t4_wdata", o_mem_wdata, 32'hDEAD_BEEF);
    check("t4_wr_type", 32'(o_mem_wr_type), 32'd2);
    check("t4_no_early_ack", 32'(o_ls_valid), 32'd0);
    cyc();
    idle();
    i_ls_rd_en = 1'b1; i_ls_addr = 32'h200; i_ls_rd_type = 3'b010;
    @(negedge clk);
    check("t4_st_ack", 32'(o_ls_valid), 32'd1);
    check("t4_ld_rd_en", 32'(o_mem_rd_en), 32'd1);
    cyc();
    idle();
    @(negedge clk);
    check("t4_gap", 32'(o_ls_valid), 32'd0);
    cyc();
    @(negedge clk);
    check("t4_ld_valid", 32'(o_ls_valid), 32'd1);
    check("t4_ld_data", o_ls_rdata, 32'hDEAD_BEEF);

    // 4b: store ack collides with an LS load return and slips one cycle
    cyc();
    i_ls_rd_en = 1'b1; i_ls_addr = 32'h204; i_ls_rd_type = 3'b010;
    @(negedge clk);
    check("t4b_ld_valid_pre", 32'(o_ls_valid), 32'd0);
    cyc();
    idle();
    i_ls_wr_en = 1'b1; i_ls_addr = 32'h208; i_ls_wdata = 32'h1234_5678; i_ls_wr_type = 2'b10;
    @(negedge clk);
    check("t4b_quiet", 32'(o_ls_valid), 32'd0);
    cyc();
    idle();
    @(negedge clk);
    check("t4b_ld_valid", 32'(o_ls_valid), 32'd1);
    check("t4b_ld_data", o_ls_rdata, 32'hA000_0081);
    cyc();
    @(negedge clk);
    check("t4b_st_ack", 32'(o_ls_valid), 32'd1);
    check("t4b_st_ack_rdata", o_ls_rdata, 32'h0);
    cyc();
    @(negedge clk);
    check("t4b_done", 32'(o_ls_valid), 32'd0);

    // 6: idle cycles
    for (int h = 0; h < 5; h++) begin
      cyc();
      idle();
      @(negedge clk);
      check_quiet($sformatf("t6_%0d", h));
    end
    check("t6_addr_hold", o_mem_addr, 32'h208);
    check("t6_wdata_hold", o_mem_wdata, 32'h1234_5678);

    // 5: reset with two reads in flight
    cyc();
    i_if_req = 1'b1; i_if_addr = 32'h0;
    cyc();
    idle();
    i_ls_rd_en = 1'b1; i_ls_addr = 32'h100; i_ls_rd_type = 3'b010;
    cyc();
    rst = 1'b1;
    i_if_req = 1'b1; i_if_addr = 32'h40;
    @(negedge clk);
    check_quiet("t5_rst");
    check("t5_addr", o_mem_addr, 32'h0);
    check("t5_wdata", o_mem_wdata, 32'h0);
    check("t5_instr", o_if_instr, 32'h0);
    check("t5_rdata", o_ls_rdata, 32'h0);
    cyc();
    rst = 1'b0;
    idle();
    for (int g = 0; g < 3; g++) begin
      if (g > 0) cyc();
      @(negedge clk);
      check($sformatf("t5_if_vld_%0d", g), 32'(o_if_valid), 32'd0);
      check($sformatf("t5_ls_vld_%0d", g), 32'(o_ls_valid), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
